// File: rtl/spi_servo_regfile.sv
// spi_servo_regfile: decodes SPI command frames into an LED register and
// NUM_CH 8-bit servo position registers (ID, LED, WRITE, BURST, READ).
// Optional feature macro: SPI_SHADOW_COMMIT_EN -- when defined, servo writes
// are staged with per-channel dirty bits and committed together at frame end.
module spi_servo_regfile #(
  parameter int         NUM_CH   = 18,
  parameter logic [7:0] PWM_INIT = 8'd0,
  parameter logic [7:0] ID_BYTE  = 8'hD4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ncs,
  input  logic [1:0]            iDone,
  input  logic [7:0]            iData,
  output logic                  oCall,
  output logic [7:0]            oData,
  output logic [2:0]            oLED_Sig,
  output logic [8*NUM_CH-1:0]   oPWM_Sig,
  output logic                  oUpdate,
  output logic [7:0]            oErrCnt
);

  localparam logic [7:0] CH_LIMIT = 8'(NUM_CH);
  localparam logic [7:0] OP_ID    = 8'h06;
  localparam logic [7:0] OP_LED   = 8'hA1;
  localparam logic [7:0] OP_WRITE = 8'hA3;
  localparam logic [7:0] OP_BURST = 8'hA5;
  localparam logic [7:0] OP_READ  = 8'hA6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ARG_CH,
    ST_ARG_VAL,
    ST_BURST,
    ST_FETCH,
    ST_REPLY,
    ST_DRAIN
  } state_t;

  state_t state_r, state_s;

  logic [2:0]              ncs_sync_r;
  logic                    ncs_t_s;
  logic                    ncs_t_d_r;
  logic                    frame_end_s;
  logic                    byte_s;
  logic                    sent_s;

  logic [7:0]              cmd_r;
  logic [7:0]              ch_r;
  logic                    ovf_r;
  logic                    call_r;
  logic [7:0]              data_r;
  logic [2:0]              led_r;
  logic [7:0]              err_r;
  logic                    upd_r;
  logic [NUM_CH-1:0][7:0]  pwm_r;

  logic                    cmd_ld_s;
  logic                    ch_ld_s;
  logic                    ch_inc_s;
  logic                    wr_s;
  logic                    led_we_s;
  logic                    err_s;
  logic                    ovf_set_s;
  logic                    reply_set_s;
  logic                    reply_clr_s;
  logic [7:0]              reply_val_s;
  logic [7:0]              rd_val_s;

  assign byte_s      = iDone[0];
  assign sent_s      = iDone[1];
  assign ncs_t_s     = ncs_sync_r[2];
  assign frame_end_s = ncs_t_s & ~ncs_t_d_r;

  assign oCall    = call_r;
  assign oData    = data_r;
  assign oLED_Sig = led_r;
  assign oPWM_Sig = pwm_r;
  assign oUpdate  = upd_r;
  assign oErrCnt  = err_r;

  // Synchronize chip select and keep the previous value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      ncs_sync_r <= 3'b111;
      ncs_t_d_r  <= 1'b1;
    end else begin
      ncs_sync_r <= {ncs_sync_r[1:0], ncs};
      ncs_t_d_r  <= ncs_t_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and datapath strobes; frame end overrides everything.
  always_comb begin
    state_s     = state_r;
    cmd_ld_s    = 1'b0;
    ch_ld_s     = 1'b0;
    ch_inc_s    = 1'b0;
    wr_s        = 1'b0;
    led_we_s    = 1'b0;
    err_s       = 1'b0;
    ovf_set_s   = 1'b0;
    reply_set_s = 1'b0;
    reply_clr_s = 1'b0;
    reply_val_s = 8'd0;
    if (frame_end_s) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (byte_s) begin
            cmd_ld_s = 1'b1;
            state_s  = ST_CMD;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_CMD: begin
          case (cmd_r)
            OP_ID: begin
              reply_set_s = 1'b1;
              reply_val_s = ID_BYTE;
              state_s     = ST_REPLY;
            end
            OP_LED:                     state_s = ST_ARG_VAL;
            OP_WRITE, OP_BURST, OP_READ: state_s = ST_ARG_CH;
            default: begin
              err_s   = 1'b1;
              state_s = ST_DRAIN;
            end
          endcase
        end
        ST_ARG_CH: begin
          if (!byte_s) begin
            state_s = ST_ARG_CH;
          end else if (iData >= CH_LIMIT) begin
            err_s   = 1'b1;
            state_s = ST_DRAIN;
          end else begin
            ch_ld_s = 1'b1;
            if (cmd_r == OP_WRITE) begin
              state_s = ST_ARG_VAL;
            end else if (cmd_r == OP_BURST) begin
              state_s = ST_BURST;
            end else begin
              state_s = ST_FETCH;
            end
          end
        end
        ST_ARG_VAL: begin
          if (byte_s) begin
            if (cmd_r == OP_LED) begin
              led_we_s = 1'b1;
            end else begin
              wr_s = 1'b1;
            end
            state_s = ST_IDLE;
          end else begin
            state_s = ST_ARG_VAL;
          end
        end
        ST_BURST: begin
          if (!byte_s) begin
            state_s = ST_BURST;
          end else if (ch_r < CH_LIMIT) begin
            wr_s     = 1'b1;
            ch_inc_s = 1'b1;
          end else if (!ovf_r) begin
            err_s     = 1'b1;
            ovf_set_s = 1'b1;
          end else begin
            state_s = ST_BURST;
          end
        end
        ST_FETCH: begin
          reply_set_s = 1'b1;
          reply_val_s = rd_val_s;
          state_s     = ST_REPLY;
        end
        ST_REPLY: begin
          // A byte received together with the transmit-done is dropped.
          if (sent_s) begin
            reply_clr_s = 1'b1;
            state_s     = ST_IDLE;
          end else begin
            state_s = ST_REPLY;
          end
        end
        ST_DRAIN: state_s = ST_DRAIN;
        default:  state_s = ST_IDLE;
      endcase
    end
  end

  // Command, channel pointer and per-frame burst overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_r <= 8'd0;
      ch_r  <= 8'd0;
      ovf_r <= 1'b0;
    end else begin
      if (cmd_ld_s) cmd_r <= iData;
      if (ch_ld_s) begin
        ch_r <= iData;
      end else if (ch_inc_s) begin
        ch_r <= ch_r + 8'd1;
      end
      if (frame_end_s) begin
        ovf_r <= 1'b0;
      end else if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Transmit request and reply byte, cleared on transmit-done or frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      call_r <= 1'b0;
      data_r <= 8'd0;
    end else if (frame_end_s || reply_clr_s) begin
      call_r <= 1'b0;
      data_r <= 8'd0;
    end else if (reply_set_s) begin
      call_r <= 1'b1;
      data_r <= reply_val_s;
    end
  end

  // LED register is always written immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r <= 3'd0;
    end else if (led_we_s) begin
      led_r <= iData[2:0];
    end
  end

  // Saturating protocol-error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 8'd0;
    end else if (err_s && (err_r != 8'hFF)) begin
      err_r <= err_r + 8'd1;
    end
  end

`ifdef SPI_SHADOW_COMMIT_EN
  logic [NUM_CH-1:0][7:0] stage_r;
  logic [NUM_CH-1:0]      dirty_r;

  // Staged writes mark channels dirty; frame end copies dirty channels out.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= {NUM_CH{PWM_INIT}};
      dirty_r <= '0;
      pwm_r   <= {NUM_CH{PWM_INIT}};
      upd_r   <= 1'b0;
    end else begin
      upd_r <= frame_end_s && (|dirty_r);
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_s && (ch_r == 8'(k))) begin
          stage_r[k] <= iData;
          dirty_r[k] <= 1'b1;
        end else if (frame_end_s && dirty_r[k]) begin
          pwm_r[k]   <= stage_r[k];
          dirty_r[k] <= 1'b0;
        end
      end
    end
  end

  // Readback selects the staged value.
  always_comb begin
    rd_val_s = 8'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_r == 8'(k)) begin
        rd_val_s = stage_r[k];
      end else begin
        rd_val_s = rd_val_s;
      end
    end
  end
`else
  // Writes go straight to the outputs with one update pulse per write.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_r <= {NUM_CH{PWM_INIT}};
      upd_r <= 1'b0;
    end else begin
      upd_r <= wr_s;
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_s && (ch_r == 8'(k))) pwm_r[k] <= iData;
      end
    end
  end

  // Readback selects the live output value.
  always_comb begin
    rd_val_s = 8'd0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_r == 8'(k)) begin
        rd_val_s = pwm_r[k];
      end else begin
        rd_val_s = rd_val_s;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_servo_regfile.sv
// Self-checking bench for spi_servo_regfile (NUM_CH=18), valid with or
// without SPI_SHADOW_COMMIT_EN. Replies are checked through a scoreboard queue.
module tb_spi_servo_regfile;
  localparam int NCH = 18;
`ifdef SPI_SHADOW_COMMIT_EN
  localparam bit COMMIT = 1'b1;
`else
  localparam bit COMMIT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ncs;
  logic [1:0]           iDone;
  logic [7:0]           iData;
  logic                 oCall;
  logic [7:0]           oData;
  logic [2:0]           oLED_Sig;
  logic [8*NCH-1:0]     oPWM_Sig;
  logic                 oUpdate;
  logic [7:0]           oErrCnt;

  int                   checks = 0;
  int                   errors = 0;
  int                   upd_cnt = 0;
  logic [8*NCH-1:0]     exp_vec;
  logic [7:0]           exp_err;
  logic [7:0]           reply_q[$];

  spi_servo_regfile #(.NUM_CH(NCH), .PWM_INIT(8'd0), .ID_BYTE(8'hD4)) dut (
    .clk(clk), .rst(rst), .ncs(ncs), .iDone(iDone), .iData(iData),
    .oCall(oCall), .oData(oData), .oLED_Sig(oLED_Sig), .oPWM_Sig(oPWM_Sig),
    .oUpdate(oUpdate), .oErrCnt(oErrCnt)
  );

  always #5 clk = ~clk;

  // Count update pulses away from the active edge.
  always @(negedge clk) begin
    if (oUpdate === 1'b1) upd_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); iData = b; iDone = 2'b01;
    @(negedge clk); iDone = 2'b00;
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b);
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_begin();
    @(negedge clk); ncs = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic frame_finish();
    repeat (2) @(negedge clk); ncs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_call(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (oCall === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ncs = 1'b1; iDone = 2'b00; iData = 8'd0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_vec = '0; exp_err = 8'd0;
    checks++; if (oCall !== 1'b0) begin errors++; $display("FAIL reset_call got %b want 0", oCall); end
    checks++; if (oData !== 8'd0) begin errors++; $display("FAIL reset_data got %h want 00", oData); end
    checks++; if (oLED_Sig !== 3'd0) begin errors++; $display("FAIL reset_led got %b want 000", oLED_Sig); end
    checks++; if (oPWM_Sig !== exp_vec) begin errors++; $display("FAIL reset_pwm got %h want %h", oPWM_Sig, exp_vec); end
    checks++; if (oUpdate !== 1'b0) begin errors++; $display("FAIL reset_upd got %b want 0", oUpdate); end
    checks++; if (oErrCnt !== 8'd0) begin errors++; $display("FAIL reset_err got %h want 00", oErrCnt); end
  endtask

  task automatic test_id();
    logic [7:0] exp;
    frame_begin();
    reply_q.push_back(8'hD4);
    send_byte(8'h06);
    checks++; if (oCall !== 1'b0) begin errors++; $display("FAIL id_early got %b want 0", oCall); end
    @(negedge clk);
    exp = reply_q.pop_front();
    checks++; if (oCall !== 1'b1) begin errors++; $display("FAIL id_call got %b want 1", oCall); end
    checks++; if (oData !== exp) begin errors++; $display("FAIL id_data got %h want %h", oData, exp); end
    send(8'hEE);
    checks++; if (oCall !== 1'b1 || oData !== exp) begin
      errors++; $display("FAIL id_dummy got call=%b data=%h want 1/%h", oCall, oData, exp);
    end
    @(negedge clk); iDone = 2'b10;
    @(negedge clk); iDone = 2'b00;
    checks++; if (oCall !== 1'b0 || oData !== 8'd0) begin
      errors++; $display("FAIL id_clear got call=%b data=%h want 0/00", oCall, oData);
    end
    frame_finish();
  endtask

  task automatic test_led();
    int base;
    base = upd_cnt;
    frame_begin();
    send(8'hA1); send(8'h05);
    checks++; if (oLED_Sig !== 3'b101) begin errors++; $display("FAIL led_val got %b want 101", oLED_Sig); end
    frame_finish();
    checks++; if (oPWM_Sig !== exp_vec) begin errors++; $display("FAIL led_pwm got %h want %h", oPWM_Sig, exp_vec); end
    checks++; if (upd_cnt !== base) begin errors++; $display("FAIL led_upd got %0d want %0d", upd_cnt, base); end
  endtask

  task automatic test_write();
    int base;
    logic [7:0] exp_early;
    base = upd_cnt;
    exp_early = COMMIT ? 8'h00 : 8'h7F;
    frame_begin();
    send(8'hA3); send(8'h02); send_byte(8'h7F);
    checks++; if (oPWM_Sig[16 +: 8] !== exp_early) begin
      errors++; $display("FAIL write_immediate got %h want %h", oPWM_Sig[16 +: 8], exp_early);
    end
    repeat (2) @(negedge clk); ncs = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (oPWM_Sig[16 +: 8] !== exp_early) begin
      errors++; $display("FAIL write_precommit got %h want %h", oPWM_Sig[16 +: 8], exp_early);
    end
    @(negedge clk);
    exp_vec[16 +: 8] = 8'h7F;
    checks++; if (oPWM_Sig !== exp_vec) begin errors++; $display("FAIL write_commit got %h want %h", oPWM_Sig, exp_vec); end
    repeat (4) @(negedge clk);
    checks++; if (upd_cnt !== base + 1) begin errors++; $display("FAIL write_upd got %0d want %0d", upd_cnt, base + 1); end
  endtask

  task automatic test_burst();
    int base;
    base = upd_cnt;
    frame_begin();
    send(8'hA5); send(8'h10); send(8'h11); send(8'h22); send(8'h33);
    frame_finish();
    exp_vec[128 +: 8] = 8'h11; exp_vec[136 +: 8] = 8'h22;
    exp_err = exp_err + 8'd1;
    checks++; if (oPWM_Sig !== exp_vec) begin errors++; $display("FAIL burst_pwm got %h want %h", oPWM_Sig, exp_vec); end
    checks++; if (oErrCnt !== exp_err) begin errors++; $display("FAIL burst_err got %h want %h", oErrCnt, exp_err); end
    checks++; if (upd_cnt !== base + (COMMIT ? 1 : 2)) begin
      errors++; $display("FAIL burst_upd got %0d want %0d", upd_cnt, base + (COMMIT ? 1 : 2));
    end
  endtask

  task automatic test_errors();
    frame_begin();
    send(8'hA3); send(8'h12); send(8'h55);
    frame_finish();
    exp_err = exp_err + 8'd1;
    checks++; if (oErrCnt !== exp_err) begin errors++; $display("FAIL range_err got %h want %h", oErrCnt, exp_err); end
    checks++; if (oPWM_Sig !== exp_vec) begin errors++; $display("FAIL range_pwm got %h want %h", oPWM_Sig, exp_vec); end
    frame_begin();
    send(8'h77); send(8'hA1); send(8'h02);
    frame_finish();
    exp_err = exp_err + 8'd1;
    checks++; if (oErrCnt !== exp_err) begin errors++; $display("FAIL opcode_err got %h want %h", oErrCnt, exp_err); end
    checks++; if (oLED_Sig !== 3'b101) begin errors++; $display("FAIL opcode_drain got %b want 101", oLED_Sig); end
  endtask

  task automatic test_readback();
    bit to;
    logic [7:0] exp;
    frame_begin();
    send(8'hA6);
    reply_q.push_back(8'h11);
    send_byte(8'h10);
    wait_call(to);
    checks++; if (to) begin errors++; $display("FAIL read_timeout got no call want call"); end
    exp = reply_q.pop_front();
    checks++; if (oData !== exp) begin errors++; $display("FAIL read_data got %h want %h", oData, exp); end
    @(negedge clk); iData = 8'h77; iDone = 2'b11;
    @(negedge clk); iDone = 2'b00;
    checks++; if (oCall !== 1'b0) begin errors++; $display("FAIL read_clear got %b want 0", oCall); end
    repeat (3) @(negedge clk);
    send(8'hA1); send(8'h03);
    checks++; if (oLED_Sig !== 3'b011) begin errors++; $display("FAIL read_dropbyte_led got %b want 011", oLED_Sig); end
    checks++; if (oErrCnt !== exp_err) begin errors++; $display("FAIL read_dropbyte_err got %h want %h", oErrCnt, exp_err); end
    frame_finish();
  endtask

  task automatic test_abort();
    int base;
    bit to;
    logic [7:0] exp;
    base = upd_cnt;
    frame_begin();
    send(8'hA3); send(8'h03);
    frame_finish();
    checks++; if (oPWM_Sig !== exp_vec) begin errors++; $display("FAIL abort_pwm got %h want %h", oPWM_Sig, exp_vec); end
    checks++; if (upd_cnt !== base) begin errors++; $display("FAIL abort_upd got %0d want %0d", upd_cnt, base); end
    frame_begin();
    reply_q.push_back(8'hD4);
    send_byte(8'h06);
    wait_call(to);
    checks++; if (to) begin errors++; $display("FAIL abort_id_timeout got no call want call"); end
    exp = reply_q.pop_front();
    checks++; if (oData !== exp) begin errors++; $display("FAIL abort_id_data got %h want %h", oData, exp); end
    @(negedge clk); iDone = 2'b10;
    @(negedge clk); iDone = 2'b00;
    frame_finish();
    checks++; if (oErrCnt !== exp_err) begin errors++; $display("FAIL abort_err got %h want %h", oErrCnt, exp_err); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = upd_cnt;
    frame_begin();
    send(8'hA3);
    @(negedge clk); iData = 8'h05; iDone = 2'b01;
    @(negedge clk); iData = 8'h3C;
    @(negedge clk); iDone = 2'b00;
    frame_finish();
    exp_vec[40 +: 8] = 8'h3C;
    checks++; if (oPWM_Sig !== exp_vec) begin errors++; $display("FAIL b2b_write got %h want %h", oPWM_Sig, exp_vec); end
    frame_begin();
    send(8'hA5); send(8'h00);
    @(negedge clk); iData = 8'h01; iDone = 2'b01;
    @(negedge clk); iData = 8'h02;
    @(negedge clk); iData = 8'h03;
    @(negedge clk); iDone = 2'b00;
    frame_finish();
    exp_vec[0 +: 8] = 8'h01; exp_vec[8 +: 8] = 8'h02; exp_vec[16 +: 8] = 8'h03;
    checks++; if (oPWM_Sig !== exp_vec) begin errors++; $display("FAIL b2b_burst got %h want %h", oPWM_Sig, exp_vec); end
    checks++; if (upd_cnt !== base + (COMMIT ? 2 : 4)) begin
      errors++; $display("FAIL b2b_upd got %0d want %0d", upd_cnt, base + (COMMIT ? 2 : 4));
    end
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 256; i++) begin
      frame_begin();
      send(8'h77);
      frame_finish();
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    end
    checks++; if (oErrCnt !== exp_err) begin errors++; $display("FAIL err_saturate got %h want %h", oErrCnt, exp_err); end
  endtask

  initial begin
    test_reset();
    test_id();
    test_led();
    test_write();
    test_burst();
    test_errors();
    test_readback();
    test_abort();
    test_back_to_back();
    test_err_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
